// File: rtl/controle_fase_pkg.sv
// Shared definitions for the naval-battle phase controller: phase encodings
// (also used by the display and grid blocks) and default game sizes.
package controle_fase_pkg;

  typedef enum logic [1:0] {
    DESLIGADO = 2'd0,
    POSICIONA = 2'd1,
    ATAQUE    = 2'd2,
    FIM       = 2'd3
  } fase_t;

  localparam int N_NAVIOS_DEF   = 3;
  localparam int MAX_TIROS_DEF  = 8;
  localparam int ALVOS_DEF      = 3;
  localparam int DEB_CICLOS_DEF = 500000;

  // The encoder shows attack symbols both while shooting and once the game is over.
  function automatic logic em_ataque(input fase_t f);
    return (f == ATAQUE) || (f == FIM);
  endfunction

endpackage

// File: rtl/controle_fase_debounce_botao.sv
// Confirm-button conditioning: 2-FF synchronizer, stability counter and a
// single-cycle pulse on the debounced released->pressed edge.
module debounce_botao
  import controle_fase_pkg::*;
#(
  parameter int DEB_CICLOS = DEB_CICLOS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic conf
);

  localparam int CW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_LIM = CW'(DEB_CICLOS - 1);

  logic          press_m;
  logic          press_s;
  logic          nivel;
  logic [CW-1:0] cnt;

  // Bring the raw button into the clock domain, already inverted so 1 = pressed
  // and the reset value means released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_m <= 1'b0;
      press_s <= 1'b0;
    end else begin
      press_m <= ~btn_n;
      press_s <= press_m;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any agreeing
  // sample restarts the count, and only a press (not a release) emits a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      nivel <= 1'b0;
      conf  <= 1'b0;
    end else begin
      conf <= 1'b0;
      if (press_s == nivel) begin
        cnt <= '0;
      end else if (cnt == CNT_LIM) begin
        cnt   <= '0;
        nivel <= press_s;
        conf  <= press_s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/controle_fase.sv
// Game-phase controller: power-switch synchronizer, debounced confirm button,
// phase FSM and the ship/shot/hit counters feeding the state display encoder.
module controle_fase
  import controle_fase_pkg::*;
#(
  parameter int N_NAVIOS   = N_NAVIOS_DEF,
  parameter int MAX_TIROS  = MAX_TIROS_DEF,
  parameter int ALVOS      = ALVOS_DEF,
  parameter int DEB_CICLOS = DEB_CICLOS_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sw_on,
  input  logic                           btn_conf_n,
  input  logic                           acerto,
  output logic                           ligado,
  output logic                           ataque,
  output logic                           tiro,
  output logic                           fim,
  output logic                           vitoria,
  output logic [$clog2(N_NAVIOS+1)-1:0]  navios,
  output logic [$clog2(MAX_TIROS+1)-1:0] tiros,
  output logic [$clog2(ALVOS+1)-1:0]     acertos
);

  localparam int NW = $clog2(N_NAVIOS + 1);
  localparam int TW = $clog2(MAX_TIROS + 1);
  localparam int AW = $clog2(ALVOS + 1);

  localparam logic [NW-1:0] NAV_FIM = NW'(N_NAVIOS);
  localparam logic [TW-1:0] TIR_FIM = TW'(MAX_TIROS);
  localparam logic [AW-1:0] ALV_FIM = AW'(ALVOS);

  logic on_m;
  logic on_s;
  logic conf;

  fase_t          fase;
  fase_t          fase_n;
  logic [NW-1:0]  navios_n;
  logic [TW-1:0]  tiros_n;
  logic [AW-1:0]  acertos_n;
  logic           vitoria_n;
  logic           tiro_n;
  logic [NW-1:0]  navios_inc;
  logic [TW-1:0]  tiros_inc;

  debounce_botao #(
    .DEB_CICLOS(DEB_CICLOS)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(btn_conf_n),
    .conf (conf)
  );

  // Power switch is asynchronous to the board clock, so resynchronize it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_m <= 1'b0;
      on_s <= 1'b0;
    end else begin
      on_m <= sw_on;
      on_s <= on_m;
    end
  end

  // Phase and counter registers; every value the encoder sees comes from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fase    <= DESLIGADO;
      navios  <= '0;
      tiros   <= '0;
      acertos <= '0;
      vitoria <= 1'b0;
      tiro    <= 1'b0;
    end else begin
      fase    <= fase_n;
      navios  <= navios_n;
      tiros   <= tiros_n;
      acertos <= acertos_n;
      vitoria <= vitoria_n;
      tiro    <= tiro_n;
    end
  end

  // Next phase and counter values; switching off wins over any confirm in the same cycle.
  always_comb begin
    fase_n     = fase;
    navios_n   = navios;
    tiros_n    = tiros;
    acertos_n  = acertos;
    vitoria_n  = vitoria;
    tiro_n     = 1'b0;
    navios_inc = navios + NW'(1);
    tiros_inc  = tiros + TW'(1);

    if (!on_s) begin
      fase_n    = DESLIGADO;
      navios_n  = '0;
      tiros_n   = '0;
      acertos_n = '0;
      vitoria_n = 1'b0;
    end else begin
      case (fase)
        DESLIGADO: fase_n = POSICIONA;
        POSICIONA: begin
          if (conf) begin
            navios_n = navios_inc;
            if (navios_inc == NAV_FIM) fase_n = ATAQUE;
          end
        end
        ATAQUE: begin
          if (conf) begin
            tiro_n  = 1'b1;
            tiros_n = tiros_inc;
            if (acerto) acertos_n = acertos + AW'(1);
            if (acertos_n == ALV_FIM) begin
              fase_n    = FIM;
              vitoria_n = 1'b1;
            end else if (tiros_inc == TIR_FIM) begin
              fase_n    = FIM;
              vitoria_n = 1'b0;
            end
          end
        end
        FIM:     fase_n = FIM;
        default: fase_n = DESLIGADO;
      endcase
    end
  end

  // Encoder-facing status decoded straight from the registered phase.
  always_comb begin
    ligado = (fase != DESLIGADO);
    ataque = em_ataque(fase);
    fim    = (fase == FIM);
  end

endmodule
